// File: rtl/seq_detect_moore.sv
// Parametrised Moore serial-pattern detector with overlap / non-overlap modes.
// Define SEQ_DET_COUNT_EN to build the saturating match counter (count, cnt_sat).
module seq_detect_moore #(
  parameter int unsigned           LEN     = 2,
  parameter logic [LEN-1:0]        PATTERN = 2'b01,
  parameter bit                    OVERLAP = 1'b1,
  parameter int unsigned           CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             a,
  input  logic             clr,
  output logic             y,
  output logic [LEN-1:0]   hist
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0] count,
  output logic             cnt_sat
`endif
);

  localparam int unsigned    FW   = $clog2(LEN + 1);
  localparam logic [FW-1:0]  FULL = FW'(LEN);

  logic [LEN-1:0] histQ;
  logic [LEN-1:0] histD;
  logic [FW-1:0]  fillQ;
  logic [FW-1:0]  fillD;
  logic           yQ;
  logic           hit;

  generate
    if (LEN == 1) begin : gShort
      assign histD = a;
    end else begin : gLong
      assign histD = {histQ[LEN-2:0], a};
    end
  endgenerate

  // Fill saturates at LEN; a match is only possible once LEN samples are in.
  assign fillD = (fillQ == FULL) ? fillQ : fillQ + FW'(1);
  assign hit   = (fillD == FULL) && (histD == PATTERN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      histQ <= '0;
      fillQ <= '0;
      yQ    <= 1'b0;
    end else if (clr) begin
      histQ <= '0;
      fillQ <= '0;
      yQ    <= 1'b0;
    end else if (valid) begin
      histQ <= histD;
      yQ    <= hit;
      // Non-overlap mode restarts the fill so the next match needs LEN fresh bits.
      fillQ <= (!OVERLAP && hit) ? '0 : fillD;
    end
  end

  assign y    = yQ;
  assign hist = histQ;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] countQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      countQ <= '0;
    end else if (clr) begin
      countQ <= '0;
    end else if (valid && hit && !(&countQ)) begin
      countQ <= countQ + CNT_W'(1);
    end
  end

  assign count   = countQ;
  assign cnt_sat = &countQ;
`endif

endmodule

// File: tb/tb_seq_detect_moore.sv
// Bench for seq_detect_moore: three instances share one input stream and are
// checked against a sample-queue reference model; honours SEQ_DET_COUNT_EN.
module tb_seq_detect_moore;

  logic       clk = 1'b0;
  logic       reset, valid, a, clr;
  logic       yO, yN, y1;
  logic [3:0] hO, hN;
  logic [0:0] h1;
`ifdef SEQ_DET_COUNT_EN
  logic [7:0] cO, cN;
  logic [1:0] c1;
  logic       sO, sN, s1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detect_moore #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) uOver (
    .clk(clk), .reset(reset), .valid(valid), .a(a), .clr(clr), .y(yO), .hist(hO)
`ifdef SEQ_DET_COUNT_EN
    , .count(cO), .cnt_sat(sO)
`endif
  );

  seq_detect_moore #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) uNon (
    .clk(clk), .reset(reset), .valid(valid), .a(a), .clr(clr), .y(yN), .hist(hN)
`ifdef SEQ_DET_COUNT_EN
    , .count(cN), .cnt_sat(sN)
`endif
  );

  seq_detect_moore #(.LEN(1), .PATTERN(1'b1), .OVERLAP(1'b1), .CNT_W(2)) uOne (
    .clk(clk), .reset(reset), .valid(valid), .a(a), .clr(clr), .y(y1), .hist(h1)
`ifdef SEQ_DET_COUNT_EN
    , .count(c1), .cnt_sat(s1)
`endif
  );

  // Reference model: every accepted sample since the last reset/clr.
  bit smp[$];
  int lastHitN;
  bit expYO, expYN, expY1;
  int cntO, cntN, cnt1;

  function automatic logic [31:0] lastBits(int k);
    logic [31:0] r = '0;
    int n = smp.size();
    for (int i = 0; i < k; i++)
      if (n - 1 - i >= 0) r[i] = smp[n-1-i];
    return r;
  endfunction

  task automatic modelClear();
    smp.delete();
    lastHitN = 0;
    expYO = 0; expYN = 0; expY1 = 0;
    cntO = 0; cntN = 0; cnt1 = 0;
  endtask

  task automatic modelSample(bit b);
    int n;
    bit m;
    smp.push_back(b);
    n = smp.size();
    m = (n >= 4) && (lastBits(4) == 32'hB);
    expYO = m;
    expYN = m && (n - lastHitN >= 4);
    if (expYN) lastHitN = n;
    expY1 = b;
    if (expYO && cntO < 255) cntO++;
    if (expYN && cntN < 255) cntN++;
    if (expY1 && cnt1 < 3) cnt1++;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(logic v, logic b, logic c);
    valid = v; a = b; clr = c;
    @(posedge clk);
    #1;
    if (c) modelClear();
    else if (v) modelSample(b);
  endtask

  task automatic checkOutput(string tag);
    check({tag, ".yO"}, 32'(yO), 32'(expYO));
    check({tag, ".yN"}, 32'(yN), 32'(expYN));
    check({tag, ".y1"}, 32'(y1), 32'(expY1));
    check({tag, ".hO"}, 32'(hO), lastBits(4));
    check({tag, ".hN"}, 32'(hN), lastBits(4));
    check({tag, ".h1"}, 32'(h1), lastBits(1));
`ifdef SEQ_DET_COUNT_EN
    check({tag, ".cO"}, 32'(cO), 32'(cntO));
    check({tag, ".cN"}, 32'(cN), 32'(cntN));
    check({tag, ".c1"}, 32'(c1), 32'(cnt1));
    check({tag, ".sO"}, 32'(sO), 32'(cntO == 255));
    check({tag, ".s1"}, 32'(s1), 32'(cnt1 == 3));
`endif
  endtask

  typedef struct {
    logic       v;
    logic       b;
    logic       c;
    logic       eyO;
    logic       eyN;
    logic [3:0] eh;
  } vec_t;

  vec_t tab[10];
  bit   stream[7] = '{1, 0, 1, 1, 0, 1, 1};

  initial begin
    tab[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001};
    tab[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010};
    tab[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101};
    tab[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1011};
    tab[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110};
    tab[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101};
    tab[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011};
    tab[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111};
    tab[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111};
    tab[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};

    reset = 1'b1; valid = 1'b0; a = 1'b0; clr = 1'b0;
    modelClear();
    #12;
    checkOutput("reset");
    reset = 1'b0;

    // Overlap vs non-overlap stream, then a gap and a clr that swallows a sample.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tab[i].v, tab[i].b, tab[i].c);
      check($sformatf("tab%0d.yO", i), 32'(yO), 32'(tab[i].eyO));
      check($sformatf("tab%0d.yN", i), 32'(yN), 32'(tab[i].eyN));
      check($sformatf("tab%0d.hist", i), 32'(hO), 32'(tab[i].eh));
      checkOutput($sformatf("tab%0d", i));
    end

    // Asynchronous reset in the middle of a pattern.
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    #2 reset = 1'b1;
    modelClear();
    #2;
    check("midreset.y", 32'(yO), 32'd0);
    check("midreset.hist", 32'(hO), 32'd0);
    #2 reset = 1'b0;
    applyStimulus(1, 1, 0);
    check("afterreset.hist", 32'(hO), 32'b0001);
    check("afterreset.y", 32'(yO), 32'd0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    check("afterreset.match", 32'(yO), 32'd1);
    checkOutput("afterreset");

    // Valid gaps: y must hold across idle cycles.
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, stream[i], 0);
      checkOutput($sformatf("gap%0d", i));
      for (int g = 0; g < 3; g++) begin
        applyStimulus(0, ~stream[i], 0);
        checkOutput($sformatf("gap%0d.%0d", i, g));
      end
    end
    check("gap.yheld", 32'(yO), 32'd1);

    // clr and valid together on the completing bit.
    applyStimulus(0, 0, 1);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 1);
    check("clrvalid.y", 32'(yO), 32'd0);
    check("clrvalid.hist", 32'(hO), 32'd0);
    checkOutput("clrvalid");
    applyStimulus(1, 1, 0);
    check("clrvalid.next", 32'(hO), 32'b0001);

    // Saturation of the narrow counter on the LEN=1 instance.
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 0);
      check($sformatf("sat%0d.y1", i), 32'(y1), 32'd1);
`ifdef SEQ_DET_COUNT_EN
      check($sformatf("sat%0d.count", i), 32'(c1), (i < 3) ? 32'(i + 1) : 32'd3);
      check($sformatf("sat%0d.cnt_sat", i), 32'(s1), 32'(i >= 2));
`endif
      checkOutput($sformatf("sat%0d", i));
    end

    // Random stream against the reference model.
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      applyStimulus(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 40) == 0));
      checkOutput($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
